// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the IF/MEM memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_BUSY  = 2'd1,
        MEM_BUSY = 2'd2,
        RESP     = 2'd3
    } arb_state_e;

    typedef enum logic {
        REQ_IF  = 1'b0,
        REQ_MEM = 1'b1
    } req_id_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Fixed-priority arbiter sharing one memory bus between IF (read) and MEM (read/write).
// Optional stall-cycle performance counters are enabled by defining ARB_PERF_CNT_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  if_req_i,
    input  logic [ADDR_W-1:0]     if_addr_i,
    output logic [DATA_W-1:0]     if_rdata_o,
    output logic                  if_valid_o,
    output logic                  if_stall_o,

    input  logic                  mem_req_i,
    input  logic                  mem_we_i,
    input  logic [DATA_W/8-1:0]   mem_be_i,
    input  logic [ADDR_W-1:0]     mem_addr_i,
    input  logic [DATA_W-1:0]     mem_wdata_i,
    output logic [DATA_W-1:0]     mem_rdata_o,
    output logic                  mem_valid_o,
    output logic                  mem_stall_o,

    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [DATA_W/8-1:0]   bus_be_o,
    output logic [ADDR_W-1:0]     bus_addr_o,
    output logic [DATA_W-1:0]     bus_wdata_o,
    input  logic                  bus_ready_i,
    input  logic [DATA_W-1:0]     bus_rdata_i
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      perf_if_stall_cnt_o,
    output logic [CNT_W-1:0]      perf_mem_stall_cnt_o
`endif
);

    localparam int unsigned BE_W = DATA_W / 8;

    if (CNT_W == 0) begin : g_bad_cnt_w
        $error("mem_port_arbiter: CNT_W must be nonzero");
    end

    arb_state_e        state_q, state_d;
    req_id_e           grant_id;

    logic              bus_req_q,   bus_req_d;
    logic              bus_we_q,    bus_we_d;
    logic [BE_W-1:0]   bus_be_q,    bus_be_d;
    logic [ADDR_W-1:0] bus_addr_q,  bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              if_valid_q,  if_valid_d;
    logic              mem_valid_q, mem_valid_d;

    // MEM belongs to the older instruction, so it always wins a tie.
    assign grant_id = mem_req_i ? REQ_MEM : REQ_IF;

    // State and registered-output flops.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_be_q    <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_valid_q  <= 1'b0;
            mem_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_be_q    <= bus_be_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_valid_q  <= if_valid_d;
            mem_valid_q <= mem_valid_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (mem_req_i || if_req_i) begin
                    state_d = (grant_id == REQ_MEM) ? MEM_BUSY : IF_BUSY;
                end
            end
            IF_BUSY, MEM_BUSY: begin
                if (bus_ready_i) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output next-values; bus fields hold until the next grant.
    always_comb begin
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_be_d    = bus_be_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_valid_d  = 1'b0;
        mem_valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_req_i || if_req_i) begin
                    bus_req_d = 1'b1;
                    if (grant_id == REQ_MEM) begin
                        bus_we_d    = mem_we_i;
                        bus_be_d    = mem_be_i;
                        bus_addr_d  = mem_addr_i;
                        bus_wdata_d = mem_wdata_i;
                    end else begin
                        bus_we_d    = 1'b0;
                        bus_be_d    = {BE_W{1'b1}};
                        bus_addr_d  = if_addr_i;
                        bus_wdata_d = '0;
                    end
                end
            end
            IF_BUSY: begin
                if (bus_ready_i) begin
                    bus_req_d  = 1'b0;
                    if_rdata_d = bus_rdata_i;
                    if_valid_d = 1'b1;
                end
            end
            MEM_BUSY: begin
                if (bus_ready_i) begin
                    bus_req_d   = 1'b0;
                    mem_valid_d = 1'b1;
                    if (!bus_we_q) begin
                        mem_rdata_d = bus_rdata_i;
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_be_o    = bus_be_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;
    assign if_rdata_o  = if_rdata_q;
    assign mem_rdata_o = mem_rdata_q;
    assign if_valid_o  = if_valid_q;
    assign mem_valid_o = mem_valid_q;

    // Stalls release in the same cycle the valid pulse is seen.
    assign if_stall_o  = if_req_i  & ~if_valid_q;
    assign mem_stall_o = mem_req_i & ~mem_valid_q;

`ifdef ARB_PERF_CNT_EN
    sat_counter #(.CNT_W(CNT_W)) u_if_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (if_stall_o),
        .cnt_o (perf_if_stall_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_mem_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (mem_stall_o),
        .cnt_o (perf_mem_stall_cnt_o)
    );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model plus directed scenarios.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = DW / 8;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_valid, if_stall;
    logic          mem_req, mem_we;
    logic [BW-1:0] mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_valid, mem_stall;
    logic          bus_req, bus_we;
    logic [BW-1:0] bus_be;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_ready;
    logic [DW-1:0] bus_rdata;
`ifdef ARB_PERF_CNT_EN
    logic [CW-1:0] perf_if_cnt, perf_mem_cnt;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_rdata_o  (if_rdata),
        .if_valid_o  (if_valid),
        .if_stall_o  (if_stall),
        .mem_req_i   (mem_req),
        .mem_we_i    (mem_we),
        .mem_be_i    (mem_be),
        .mem_addr_i  (mem_addr),
        .mem_wdata_i (mem_wdata),
        .mem_rdata_o (mem_rdata),
        .mem_valid_o (mem_valid),
        .mem_stall_o (mem_stall),
        .bus_req_o   (bus_req),
        .bus_we_o    (bus_we),
        .bus_be_o    (bus_be),
        .bus_addr_o  (bus_addr),
        .bus_wdata_o (bus_wdata),
        .bus_ready_i (bus_ready),
        .bus_rdata_i (bus_rdata)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_if_stall_cnt_o  (perf_if_cnt),
        .perf_mem_stall_cnt_o (perf_mem_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;
    bit started  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: one outstanding transaction tracked as "who owns the bus" and "where it is".
    // phase 0 = bus free, 1 = transfer on the bus, 2 = response cycle (no grant).
    int            m_phase = 0;
    bit            m_is_mem = 1'b0;
    logic          e_bus_req = 1'b0, e_we = 1'b0;
    logic [BW-1:0] e_be = '0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_wdata = '0, e_if_rdata = '0, e_mem_rdata = '0;
    logic          e_if_valid = 1'b0, e_mem_valid = 1'b0;
    int            m_if_cnt = 0, m_mem_cnt = 0;

    always @(posedge clk) begin
        bit if_st, mem_st;
        if_st  = if_req  && !e_if_valid;
        mem_st = mem_req && !e_mem_valid;
        e_if_valid  = 1'b0;
        e_mem_valid = 1'b0;
        if (rst) begin
            m_phase = 0; e_bus_req = 0; e_we = 0; e_be = '0; e_addr = '0; e_wdata = '0;
            e_if_rdata = '0; e_mem_rdata = '0; m_if_cnt = 0; m_mem_cnt = 0;
        end else begin
            if (if_st  && m_if_cnt  < (1 << CW) - 1) m_if_cnt++;
            if (mem_st && m_mem_cnt < (1 << CW) - 1) m_mem_cnt++;
            if (m_phase == 0) begin
                if (mem_req) begin
                    m_is_mem = 1; e_we = mem_we; e_be = mem_be; e_addr = mem_addr; e_wdata = mem_wdata;
                    e_bus_req = 1; m_phase = 1;
                end else if (if_req) begin
                    m_is_mem = 0; e_we = 0; e_be = '1; e_addr = if_addr; e_wdata = '0;
                    e_bus_req = 1; m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (bus_ready) begin
                    e_bus_req = 0;
                    m_phase = 2;
                    if (m_is_mem) begin
                        e_mem_valid = 1;
                        if (!e_we) e_mem_rdata = bus_rdata;
                    end else begin
                        e_if_valid = 1;
                        e_if_rdata = bus_rdata;
                    end
                end
            end else begin
                m_phase = 0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            chk("cmp_bus_req",   64'(bus_req),   64'(e_bus_req));
            chk("cmp_if_valid",  64'(if_valid),  64'(e_if_valid));
            chk("cmp_mem_valid", 64'(mem_valid), 64'(e_mem_valid));
            chk("cmp_if_rdata",  64'(if_rdata),  64'(e_if_rdata));
            chk("cmp_mem_rdata", 64'(mem_rdata), 64'(e_mem_rdata));
            chk("cmp_if_stall",  64'(if_stall),  64'(if_req & ~e_if_valid));
            chk("cmp_mem_stall", 64'(mem_stall), 64'(mem_req & ~e_mem_valid));
            if (e_bus_req) begin
                chk("cmp_bus_we",    64'(bus_we),    64'(e_we));
                chk("cmp_bus_be",    64'(bus_be),    64'(e_be));
                chk("cmp_bus_addr",  64'(bus_addr),  64'(e_addr));
                chk("cmp_bus_wdata", 64'(bus_wdata), 64'(e_wdata));
            end
`ifdef ARB_PERF_CNT_EN
            chk("cmp_perf_if",  64'(perf_if_cnt),  64'(m_if_cnt));
            chk("cmp_perf_mem", 64'(perf_mem_cnt), 64'(m_mem_cnt));
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; if_req = 0; if_addr = '0; mem_req = 0; mem_we = 0; mem_be = '0;
        mem_addr = '0; mem_wdata = '0; bus_ready = 0; bus_rdata = '0;
        repeat (2) cyc();
        started = 1'b1;
        @(negedge clk);
        chk("rst_bus_req",  64'(bus_req),  64'h0);
        chk("rst_bus_addr", 64'(bus_addr), 64'h0);
        chk("rst_bus_be",   64'(bus_be),   64'h0);
        chk("rst_if_valid", 64'(if_valid), 64'h0);
        chk("rst_mem_rdata", 64'(mem_rdata), 64'h0);
        cyc(); rst = 0;

        // IF read, zero wait states
        cyc(); if_req = 1; if_addr = 32'h100; bus_ready = 1; bus_rdata = 32'h8C220004;
        @(negedge clk); chk("t1_c0_stall", 64'(if_stall), 64'h1); chk("t1_c0_breq", 64'(bus_req), 64'h0);
        cyc();
        @(negedge clk);
        chk("t1_c1_breq", 64'(bus_req), 64'h1); chk("t1_c1_addr", 64'(bus_addr), 64'h100);
        chk("t1_c1_be", 64'(bus_be), 64'hF);    chk("t1_c1_stall", 64'(if_stall), 64'h1);
        cyc();
        @(negedge clk);
        chk("t1_c2_valid", 64'(if_valid), 64'h1); chk("t1_c2_rdata", 64'(if_rdata), 64'h8C220004);
        chk("t1_c2_stall", 64'(if_stall), 64'h0);
        cyc(); if_req = 0; bus_ready = 0;
        @(negedge clk); chk("t1_c3_valid", 64'(if_valid), 64'h0);

        // MEM write, three wait states
        cyc(); mem_req = 1; mem_we = 1; mem_be = 4'h3; mem_addr = 32'h2000; mem_wdata = 32'hDEADBEEF;
        bus_rdata = 32'hCAFE0000;
        for (int k = 1; k <= 4; k++) begin
            cyc(); if (k == 4) bus_ready = 1;
            @(negedge clk);
            chk("t2_breq", 64'(bus_req), 64'h1); chk("t2_addr", 64'(bus_addr), 64'h2000);
            chk("t2_we", 64'(bus_we), 64'h1);    chk("t2_be", 64'(bus_be), 64'h3);
            chk("t2_wdata", 64'(bus_wdata), 64'hDEADBEEF);
            chk("t2_valid_early", 64'(mem_valid), 64'h0);
        end
        cyc(); bus_ready = 0;
        @(negedge clk);
        chk("t2_c5_valid", 64'(mem_valid), 64'h1); chk("t2_c5_rdata", 64'(mem_rdata), 64'h0);
        cyc(); mem_req = 0; mem_we = 0;

        // Simultaneous IF and MEM: MEM first, then IF
        cyc(); if_req = 1; if_addr = 32'h104; mem_req = 1; mem_be = 4'hF; mem_addr = 32'h2004;
        bus_ready = 1; bus_rdata = 32'h11;
        @(negedge clk); chk("t3_c0_istall", 64'(if_stall), 64'h1);
        cyc();
        @(negedge clk); chk("t3_c1_addr", 64'(bus_addr), 64'h2004); chk("t3_c1_istall", 64'(if_stall), 64'h1);
        cyc();
        @(negedge clk); chk("t3_c2_mvalid", 64'(mem_valid), 64'h1); chk("t3_c2_mrdata", 64'(mem_rdata), 64'h11);
        chk("t3_c2_istall", 64'(if_stall), 64'h1);
        cyc(); mem_req = 0; bus_rdata = 32'h22;
        @(negedge clk); chk("t3_c3_istall", 64'(if_stall), 64'h1);
        cyc();
        @(negedge clk); chk("t3_c4_addr", 64'(bus_addr), 64'h104); chk("t3_c4_we", 64'(bus_we), 64'h0);
        chk("t3_c4_istall", 64'(if_stall), 64'h1);
        cyc();
        @(negedge clk); chk("t3_c5_ivalid", 64'(if_valid), 64'h1); chk("t3_c5_irdata", 64'(if_rdata), 64'h22);
        cyc(); if_req = 0; bus_ready = 0;

        // Reset while MEM_BUSY abandons the access
        cyc(); mem_req = 1; mem_we = 0; mem_addr = 32'h3000; bus_rdata = 32'h33;
        cyc();
        @(negedge clk); chk("t4_c1_breq", 64'(bus_req), 64'h1);
        cyc(); rst = 1;
        cyc(); rst = 0; mem_req = 0;
        @(negedge clk);
        chk("t4_breq", 64'(bus_req), 64'h0);   chk("t4_addr", 64'(bus_addr), 64'h0);
        chk("t4_irdata", 64'(if_rdata), 64'h0); chk("t4_mvalid", 64'(mem_valid), 64'h0);
        for (int k = 0; k < 3; k++) begin
            cyc(); bus_ready = 1;
            @(negedge clk); chk("t4_no_mvalid", 64'(mem_valid), 64'h0);
        end
        bus_ready = 0;

        // Back-to-back IF with bus always ready: one valid every three cycles
        for (int c = 0; c < 10; c++) begin
            cyc();
            if (c == 0) begin if_req = 1; if_addr = 32'h200; bus_ready = 1; end
            if (c == 9) if_req = 0;
            bus_rdata = 32'h1000 + 32'(c);
            @(negedge clk);
            chk("t5_breq",  64'(bus_req),  64'((c % 3) == 1));
            chk("t5_valid", 64'(if_valid), 64'((c % 3) == 2));
            if ((c % 3) == 2) chk("t5_rdata", 64'(if_rdata), 64'(32'h1000 + 32'(c - 1)));
        end
        cyc(); bus_ready = 0;

`ifdef ARB_PERF_CNT_EN
        // Stall counter saturation
        cyc(); rst = 1;
        cyc(); rst = 0; if_req = 1;
        repeat (20) cyc();
        @(negedge clk);
        chk("t6_perf_if_sat", 64'(perf_if_cnt), 64'hF);
        chk("t6_perf_mem", 64'(perf_mem_cnt), 64'h0);
        cyc(); if_req = 0; rst = 1;
        cyc(); rst = 0;
`endif

        repeat (2) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
